// File: rtl/operation_encoder_kbd_pkg.sv
// Shared keyboard/physics codes: movement encodings, PS/2 set-2 scan codes
// and the prefix-parser state encoding.
package operation_encoder_kbd_pkg;

  localparam logic [1:0] H_NIL   = 2'd0;
  localparam logic [1:0] H_LEFT  = 2'd1;
  localparam logic [1:0] H_RIGHT = 2'd2;

  localparam logic [1:0] V_NIL   = 2'd0;
  localparam logic [1:0] V_UP    = 2'd1;
  localparam logic [1:0] V_DOWN  = 2'd2;

  localparam logic [7:0] SC_E0     = 8'hE0;
  localparam logic [7:0] SC_F0     = 8'hF0;
  localparam logic [7:0] SC_E1     = 8'hE1;
  localparam logic [7:0] SC_ACK    = 8'hFA;
  localparam logic [7:0] SC_BAT    = 8'hAA;
  localparam logic [7:0] SC_W      = 8'h1D;
  localparam logic [7:0] SC_S      = 8'h1B;
  localparam logic [7:0] SC_A      = 8'h1C;
  localparam logic [7:0] SC_D      = 8'h23;
  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_UP     = 8'h75;
  localparam logic [7:0] SC_DOWN   = 8'h72;
  localparam logic [7:0] SC_LEFT   = 8'h6B;
  localparam logic [7:0] SC_RIGHT  = 8'h74;
  localparam logic [7:0] SC_RSHIFT = 8'h59;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_GOT_E0   = 2'd1,
    ST_GOT_F0   = 2'd2,
    ST_GOT_E0F0 = 2'd3
  } ps2_state_t;

  // Opposing keys cancel, so the value 3 can never be produced.
  function automatic logic [1:0] encode_axis(input logic neg_held, input logic pos_held,
                                             input logic [1:0] neg_code,
                                             input logic [1:0] pos_code);
    if (neg_held && !pos_held)      return neg_code;
    else if (pos_held && !neg_held) return pos_code;
    else                            return 2'd0;
  endfunction

endpackage

// File: rtl/operation_encoder_kbd_prefix_fsm.sv
// PS/2 set-2 prefix parser: folds E0/F0 prefixes into one make/break strobe.
//   state       | meaning
//   ST_IDLE     | no prefix seen
//   ST_GOT_E0   | extended prefix seen
//   ST_GOT_F0   | break prefix seen
//   ST_GOT_E0F0 | extended break prefix seen
module ps2_prefix_fsm
  import operation_encoder_kbd_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       byte_valid,
  input  logic [7:0] byte_data,
  output logic       code_strobe,
  output logic       is_break,
  output logic       extended,
  output logic [7:0] code
);

  ps2_state_t state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      code_strobe <= 1'b0;
      is_break    <= 1'b0;
      extended    <= 1'b0;
      code        <= 8'h00;
    end else begin
      code_strobe <= 1'b0;
      if (byte_valid) begin
        case (state)
          ST_IDLE: begin
            if (byte_data == SC_E0)      state <= ST_GOT_E0;
            else if (byte_data == SC_F0) state <= ST_GOT_F0;
            else begin
              code_strobe <= 1'b1;
              is_break    <= 1'b0;
              extended    <= 1'b0;
              code        <= byte_data;
            end
          end
          ST_GOT_E0: begin
            if (byte_data == SC_F0)      state <= ST_GOT_E0F0;
            else if (byte_data == SC_E0) state <= ST_GOT_E0;
            else begin
              code_strobe <= 1'b1;
              is_break    <= 1'b0;
              extended    <= 1'b1;
              code        <= byte_data;
              state       <= ST_IDLE;
            end
          end
          ST_GOT_F0: begin
            code_strobe <= 1'b1;
            is_break    <= 1'b1;
            extended    <= 1'b0;
            code        <= byte_data;
            state       <= ST_IDLE;
          end
          default: begin
            code_strobe <= 1'b1;
            is_break    <= 1'b1;
            extended    <= 1'b1;
            code        <= byte_data;
            state       <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/operation_encoder_kbd.sv
// Keyboard-to-movement encoder: tracks held direction/boost keys from PS/2
// scan codes and presents registered axis codes plus a change pulse.
module operation_encoder_kbd
  import operation_encoder_kbd_pkg::*;
#(
  parameter int KEYSET = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       byte_valid,
  input  logic [7:0] byte_data,
  output logic [1:0] h_code,
  output logic [1:0] v_code,
  output logic       boost,
  output logic       key_event
);

  localparam int K_UP    = 0;
  localparam int K_DOWN  = 1;
  localparam int K_LEFT  = 2;
  localparam int K_RIGHT = 3;
  localparam int K_BOOST = 4;

  localparam logic       ALT     = (KEYSET == 1);
  localparam logic [7:0] C_UP    = ALT ? SC_UP     : SC_W;
  localparam logic [7:0] C_DOWN  = ALT ? SC_DOWN   : SC_S;
  localparam logic [7:0] C_LEFT  = ALT ? SC_LEFT   : SC_A;
  localparam logic [7:0] C_RIGHT = ALT ? SC_RIGHT  : SC_D;
  localparam logic [7:0] C_BOOST = ALT ? SC_RSHIFT : SC_LSHIFT;

  logic       code_strobe;
  logic       is_break;
  logic       extended;
  logic [7:0] code;
  logic [4:0] held;
  logic [4:0] held_next;

  ps2_prefix_fsm u_prefix (
    .clk         (clk),
    .rst         (rst),
    .byte_valid  (byte_valid),
    .byte_data   (byte_data),
    .code_strobe (code_strobe),
    .is_break    (is_break),
    .extended    (extended),
    .code        (code)
  );

  // Direction keys carry E0 only in the arrow keyset; boost never does.
  always_comb begin
    held_next = held;
    if (code_strobe) begin
      if (code == C_UP    && extended == ALT)  held_next[K_UP]    = ~is_break;
      if (code == C_DOWN  && extended == ALT)  held_next[K_DOWN]  = ~is_break;
      if (code == C_LEFT  && extended == ALT)  held_next[K_LEFT]  = ~is_break;
      if (code == C_RIGHT && extended == ALT)  held_next[K_RIGHT] = ~is_break;
      if (code == C_BOOST && extended == 1'b0) held_next[K_BOOST] = ~is_break;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      held      <= 5'b0;
      h_code    <= H_NIL;
      v_code    <= V_NIL;
      boost     <= 1'b0;
      key_event <= 1'b0;
    end else begin
      held      <= held_next;
      h_code    <= encode_axis(held_next[K_LEFT], held_next[K_RIGHT], H_LEFT, H_RIGHT);
      v_code    <= encode_axis(held_next[K_UP], held_next[K_DOWN], V_UP, V_DOWN);
      boost     <= held_next[K_BOOST];
      key_event <= (held_next != held);
    end
  end

endmodule

// File: tb/tb_operation_encoder_kbd.sv
// Directed bench for both keysets: one byte per vector, plus hand-written
// reset-abort and back-to-back sequences.
module tb_operation_encoder_kbd;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       bv0 = 1'b0, bv1 = 1'b0;
  logic [7:0] bd0 = 8'h00, bd1 = 8'h00;
  logic [1:0] h0, v0, h1, v1;
  logic       b0, b1, e0, e1;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  operation_encoder_kbd #(.KEYSET(0)) dut0 (
    .clk(clk), .rst(rst), .byte_valid(bv0), .byte_data(bd0),
    .h_code(h0), .v_code(v0), .boost(b0), .key_event(e0)
  );

  operation_encoder_kbd #(.KEYSET(1)) dut1 (
    .clk(clk), .rst(rst), .byte_valid(bv1), .byte_data(bd1),
    .h_code(h1), .v_code(v1), .boost(b1), .key_event(e1)
  );

  typedef struct {
    bit       ks;
    bit [7:0] data;
    bit [1:0] h;
    bit [1:0] v;
    bit       b;
    bit       ev;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic chk_out(input string name, input bit ks, input bit [1:0] h,
                         input bit [1:0] v, input bit b, input bit ev);
    if (ks == 1'b0) begin
      chk({name, " h"}, h0, h); chk({name, " v"}, v0, v);
      chk({name, " boost"}, b0, b); chk({name, " event"}, e0, ev);
    end else begin
      chk({name, " h"}, h1, h); chk({name, " v"}, v1, v);
      chk({name, " boost"}, b1, b); chk({name, " event"}, e1, ev);
    end
  endtask

  // Drive one byte for one cycle; return after the output-update edge.
  task automatic send(input bit ks, input bit [7:0] d);
    @(negedge clk);
    if (ks) begin bv1 = 1'b1; bd1 = d; end
    else    begin bv0 = 1'b1; bd0 = d; end
    @(negedge clk);
    bv0 = 1'b0; bv1 = 1'b0;
    @(negedge clk);
  endtask

  task automatic add(input bit ks, input bit [7:0] d, input bit [1:0] h,
                     input bit [1:0] v, input bit b, input bit ev);
    vec_t t;
    t.ks = ks; t.data = d; t.h = h; t.v = v; t.b = b; t.ev = ev;
    vecs.push_back(t);
  endtask

  initial begin
    // KEYSET 0: W/A/S/D + LShift
    add(0, 8'h1D, 0, 1, 0, 1);
    add(0, 8'h23, 2, 1, 0, 1);
    add(0, 8'h1C, 0, 1, 0, 1);
    add(0, 8'hF0, 0, 1, 0, 0);
    add(0, 8'h1C, 2, 1, 0, 1);
    add(0, 8'h12, 2, 1, 1, 1);
    add(0, 8'h12, 2, 1, 1, 0);
    add(0, 8'h12, 2, 1, 1, 0);
    add(0, 8'hF0, 2, 1, 1, 0);
    add(0, 8'h12, 2, 1, 0, 1);
    add(0, 8'hFA, 2, 1, 0, 0);
    add(0, 8'hE0, 2, 1, 0, 0);
    add(0, 8'h1D, 2, 1, 0, 0);
    add(0, 8'hF0, 2, 1, 0, 0);
    add(0, 8'h1D, 2, 0, 0, 1);
    add(0, 8'h1B, 2, 2, 0, 1);
    add(0, 8'hF0, 2, 2, 0, 0);
    add(0, 8'h23, 0, 2, 0, 1);
    // KEYSET 1: arrows + RShift
    add(1, 8'h75, 0, 0, 0, 0);
    add(1, 8'hE0, 0, 0, 0, 0);
    add(1, 8'h75, 0, 1, 0, 1);
    add(1, 8'hE0, 0, 1, 0, 0);
    add(1, 8'hF0, 0, 1, 0, 0);
    add(1, 8'h75, 0, 0, 0, 1);
    add(1, 8'h59, 0, 0, 1, 1);
    add(1, 8'hE0, 0, 0, 1, 0);
    add(1, 8'h59, 0, 0, 1, 0);
    add(1, 8'hF0, 0, 0, 1, 0);
    add(1, 8'h59, 0, 0, 0, 1);
    add(1, 8'hE0, 0, 0, 0, 0);
    add(1, 8'h6B, 1, 0, 0, 1);
    add(1, 8'hE0, 1, 0, 0, 0);
    add(1, 8'hE0, 1, 0, 0, 0);
    add(1, 8'h74, 0, 0, 0, 1);
    add(1, 8'hE0, 0, 0, 0, 0);
    add(1, 8'hF0, 0, 0, 0, 0);
    add(1, 8'h74, 1, 0, 0, 1);
    add(1, 8'hAA, 1, 0, 0, 0);
    add(1, 8'hE1, 1, 0, 0, 0);

    repeat (3) @(negedge clk);
    chk_out("reset k0", 0, 0, 0, 0, 0);
    chk_out("reset k1", 1, 0, 0, 0, 0);
    rst = 1'b0;
    @(negedge clk);

    foreach (vecs[i]) begin
      send(vecs[i].ks, vecs[i].data);
      chk_out($sformatf("vec%0d", i), vecs[i].ks, vecs[i].h, vecs[i].v,
              vecs[i].b, vecs[i].ev);
    end

    // byte_data ignored while byte_valid is low (k0 holds S)
    @(negedge clk);
    bd0 = 8'h1D; bd1 = 8'h6B;
    repeat (4) @(negedge clk);
    chk_out("novalid k0", 0, 0, 2, 0, 0);
    chk_out("novalid k1", 1, 1, 0, 0, 0);

    // back-to-back E0 F0 6B with left already held on k1
    @(negedge clk); bv1 = 1'b1; bd1 = 8'hE0;
    @(negedge clk); bd1 = 8'hF0;
    @(negedge clk); bd1 = 8'h6B;
    @(negedge clk); bv1 = 1'b0;
    chk_out("b2b before", 1, 1, 0, 0, 0);
    @(negedge clk);
    chk_out("b2b after", 1, 0, 0, 0, 1);
    @(negedge clk);
    chk("b2b event once", e1, 0);

    // partial E0 F0 discarded by reset, then 74 from IDLE
    send(1, 8'hE0);
    send(1, 8'hF0);
    chk_out("partial", 1, 0, 0, 0, 0);
    rst = 1'b1;
    #1 chk_out("rst async", 1, 0, 0, 0, 0);
    @(negedge clk); rst = 1'b0;
    send(1, 8'h74);
    chk_out("post rst 74", 1, 0, 0, 0, 0);

    // lone E0 discarded by reset: 74 must not register as right
    send(1, 8'hE0);
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    send(1, 8'h74);
    chk_out("post rst E0 74", 1, 0, 0, 0, 0);
    send(1, 8'hE0);
    send(1, 8'h74);
    chk_out("right after rst", 1, 2, 0, 0, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/operation_encoder_kbd.md
OPERATION_ENCODER_KBD -- requirements
Module: operation_encoder_kbd

Interface
REQ-001 Parameter KEYSET, default 0, selects the key map: 0 = W/A/S/D plus Left Shift; 1 = arrow keys plus Right Shift.
REQ-002 Port clk, input, 1, the single system clock.
REQ-003 Port rst, input, 1; reset is asynchronous and active-high.
REQ-004 Port byte_valid, input, 1, one-cycle strobe from the PS/2 byte receiver.
REQ-005 Port byte_data, input, 8, scan-code byte, qualified by byte_valid.
REQ-006 Port h_code, output, 2, horizontal movement code: 0 = NIL, 1 = LEFT, 2 = RIGHT.
REQ-007 Port v_code, output, 2, vertical movement code: 0 = NIL, 1 = UP, 2 = DOWN.
REQ-008 Port boost, output, 1, high while the boost key is held.
REQ-009 Port key_event, output, 1, one-cycle pulse when any tracked key changes held state.

Function
REQ-010 The block SHALL parse PS/2 set-2 bytes with a 4-state FSM: IDLE, GOT_E0, GOT_F0 and GOT_E0F0.
REQ-011 FSM transitions, evaluated only on byte_valid:
- IDLE: E0 -> GOT_E0; F0 -> GOT_F0.
- GOT_E0: F0 -> GOT_E0F0; E0 -> stays in GOT_E0.
- Any other byte -> IDLE, after the byte is processed as a make or break code in the current prefix context.
REQ-012 Tracked keys for KEYSET=0: W=1D (up), S=1B (down), A=1C (left), D=23 (right), LShift=12 (boost); none of these take the E0 prefix.
REQ-013 Tracked keys for KEYSET=1: E0 75 (up), E0 72 (down), E0 6B (left), E0 74 (right), RShift=59 (no prefix).
REQ-014 A tracked key's code SHALL match only in its own prefix context; for example, 75 without E0 SHALL be ignored.
REQ-015 A make code SHALL set the key's held bit and a break code SHALL clear it; untracked codes, FA, AA and E1 SHALL change no held bit.
REQ-016 Typematic repeat of a key that is already held SHALL change no held bit and SHALL NOT pulse key_event.
REQ-017 h_code SHALL be LEFT when only left is held, RIGHT when only right is held, and NIL when neither or both are held; v_code SHALL follow the same rule with UP and DOWN.
REQ-018 h_code and v_code SHALL never take the value 3.
REQ-019 boost SHALL equal the boost key's held bit.
REQ-020 All outputs SHALL be registered; h_code, v_code, boost and key_event SHALL update on the first clk edge after the edge that captures the final byte of a sequence, giving 1 cycle of latency.
REQ-021 byte_valid strobes on consecutive cycles SHALL each be processed, with no byte dropped.
REQ-022 byte_data SHALL be ignored in any cycle where byte_valid is low.

Reset
REQ-023 While rst is high, the block SHALL hold FSM=IDLE, all held bits=0, h_code=0, v_code=0, boost=0 and key_event=0.
REQ-024 Asserting rst in the middle of a prefix sequence SHALL discard the partial sequence; the first byte after reset release SHALL be parsed from IDLE.

Structure
REQ-025 A shared package SHALL hold H_NIL/H_LEFT/H_RIGHT, V_NIL/V_UP/V_DOWN, the scan-code constants and the FSM state encoding; PhysicsEngine and this block SHALL both import these codes from it.
REQ-026 The block SHALL contain one sub-module, ps2_prefix_fsm, which outputs a 1-cycle make/break strobe, an extended flag and the code byte; held-bit tracking and output encoding SHALL remain in the top level.
REQ-027 The implementation SHALL use no DSP resources.

Verification
REQ-028 KEYSET=0, bytes 1D then 23 -> v_code=1 (UP), h_code=2 (RIGHT), with key_event pulsing once after each byte.
REQ-029 KEYSET=0, bytes 1C then 23 with both held -> h_code=0; then F0 1C -> h_code=2.
REQ-030 KEYSET=1, bytes 75 (no prefix) -> no change; then E0 75 -> v_code=1; then E0 F0 75 -> v_code=0.
REQ-031 KEYSET=0, bytes 12, 12, 12 (typematic) -> boost=1 with a single key_event pulse; then F0 12 -> boost=0.
REQ-032 KEYSET=1, bytes E0 F0 then rst pulse, then 74 -> no held bit changes during the partial sequence; after reset release, 74 is parsed from IDLE as a non-extended, untracked code, and h_code stays 0.
REQ-033 Back-to-back byte_valid on 3 consecutive cycles carrying E0 F0 6B, after a prior E0 6B -> h_code goes 1 then 0, with no byte dropped.
